// File: rtl/imm_ext_pkg.sv
// Shared format codes and helpers for the decode-stage immediate generator.
package imm_ext_pkg;

   localparam logic [2:0] FMT_I    = 3'd0;
   localparam logic [2:0] FMT_D    = 3'd1;
   localparam logic [2:0] FMT_B    = 3'd2;
   localparam logic [2:0] FMT_CB   = 3'd3;
   localparam logic [2:0] FMT_MOVZ = 3'd4;
   localparam logic [2:0] FMT_MOVN = 3'd5;
   localparam logic [2:0] FMT_MOVK = 3'd6;
   localparam logic [2:0] FMT_RSVD = 3'd7;

   // Bit position of the 16-bit move-wide field selected by hw (0, 16, 32, 48).
   function automatic logic [5:0] movw_shift(input logic [1:0] hw);
      return {hw, 4'b0000};
   endfunction

endpackage

// File: rtl/imm_fifo.sv
// Show-ahead synchronous FIFO; head word is readable whenever count is non-zero.
module imm_fifo #(
   parameter int WIDTH = 65,
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     valid,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= din;
   end

   assign dout  = mem[rd_ptr];
   assign valid = (count != '0);

endmodule

// File: rtl/imm_extend_pipe.sv
// Decode-stage immediate generator: extends/merges the immediate for each format
// and queues results in a valid/ready FIFO so decode can run ahead of execute.
module imm_extend_pipe
   import imm_ext_pkg::*;
#(
   parameter int DATA_W   = 64,
   parameter int DEPTH    = 2,
   parameter int BR_SHIFT = 2,
   parameter int CNT_W    = 16
) (
   input  logic                    CLK,
   input  logic                    Reset,
   input  logic                    InValid,
   output logic                    InReady,
   input  logic [25:0]             InstructionBits,
   input  logic [2:0]              Control,
   input  logic [DATA_W-1:0]       OldValue,
   output logic                    OutValid,
   input  logic                    OutReady,
   output logic [DATA_W-1:0]       Extended,
   output logic                    Illegal,
   output logic [$clog2(DEPTH):0]  Occupancy,
   output logic [CNT_W-1:0]        IllegalCount
);

   localparam int OCC_W = $clog2(DEPTH) + 1;
   localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (&c) ? c : c + CNT_W'(1);
   endfunction

   logic signed [DATA_W-1:0] sx_i_p0, sx_d_p0, sx_b_p0, sx_cb_p0;
   logic [15:0]              imm16_p0;
   logic [5:0]               sh_p0;
   logic [DATA_W-1:0]        movz_p0, keep_p0, res_p0;
   logic                     is_mov_p0, ill_p0;
   logic                     accept, pop;
   logic [DATA_W:0]          head_p1;
   logic                     vld_p1;

   // ---- p0: combinational extend/merge on the request being accepted ----
   assign sx_i_p0  = {{(DATA_W-12){InstructionBits[21]}}, InstructionBits[21:10]};
   assign sx_d_p0  = {{(DATA_W-9){InstructionBits[20]}},  InstructionBits[20:12]};
   assign sx_b_p0  = {{(DATA_W-26){InstructionBits[25]}}, InstructionBits[25:0]};
   assign sx_cb_p0 = {{(DATA_W-19){InstructionBits[23]}}, InstructionBits[23:5]};

   assign imm16_p0  = InstructionBits[20:5];
   assign sh_p0     = movw_shift(InstructionBits[22:21]);
   assign movz_p0   = DATA_W'(imm16_p0) << sh_p0;
   assign keep_p0   = ~(DATA_W'(16'hFFFF) << sh_p0);
   assign is_mov_p0 = (Control == FMT_MOVZ) || (Control == FMT_MOVN) || (Control == FMT_MOVK);
   assign ill_p0    = (Control == FMT_RSVD) || (is_mov_p0 && (32'(sh_p0) >= DATA_W));

   always_comb begin
      res_p0 = '0;
      case (Control)
         FMT_I:    res_p0 = sx_i_p0;
         FMT_D:    res_p0 = sx_d_p0;
         FMT_B:    res_p0 = sx_b_p0 <<< BR_SHIFT;
         FMT_CB:   res_p0 = sx_cb_p0 <<< BR_SHIFT;
         FMT_MOVZ: res_p0 = movz_p0;
         FMT_MOVN: res_p0 = ~movz_p0;
         FMT_MOVK: res_p0 = (OldValue & keep_p0) | movz_p0;
         default:  res_p0 = '0;
      endcase
      if (ill_p0) res_p0 = '0;
   end

   // A full FIFO still accepts when the head leaves in the same cycle.
   assign InReady = (Occupancy < FULL_OCC) || OutReady;
   assign accept  = InValid && InReady;
   assign pop     = vld_p1 && OutReady;

   // ---- p1: queued results, head presented show-ahead ----
   imm_fifo #(
      .WIDTH (DATA_W + 1),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (CLK),
      .rst   (Reset),
      .push  (accept),
      .pop   (pop),
      .din   ({ill_p0, res_p0}),
      .dout  (head_p1),
      .valid (vld_p1),
      .count (Occupancy)
   );

   assign OutValid = vld_p1;
   assign Extended = vld_p1 ? head_p1[DATA_W-1:0] : '0;
   assign Illegal  = vld_p1 && head_p1[DATA_W];

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset)                 IllegalCount <= '0;
      else if (accept && ill_p0) IllegalCount <= sat_inc(IllegalCount);
   end

endmodule
